spi_mult_frame_ctrl: RTL and testbench
======================================

Name: spi_mult_frame_ctrl

Overview:
Transaction controller that sits between the SPI slave-side transfer engine and the core datapath.
- Requests two 16-bit operand words over SPI and multiplies them in a sequential shift-add unit.
- Returns the 32-bit product as two 16-bit SPI words, high word first.
- Drives the SPI engine's rx/tx start strobes and consumes its received word, rx_valid and tx_done.

Parameters:
DATA_WIDTH, 16, operand and SPI word width; product is 2*DATA_WIDTH.
TIMEOUT_CYCLES, 65535, maximum clk cycles spent waiting for operand B; 0 disables the timeout.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
enable  input  1  when high, IDLE launches a new frame
rx_data  input  DATA_WIDTH  received word from the SPI engine
rx_valid  input  1  one-cycle pulse; rx_data is valid
tx_done  input  1  one-cycle pulse; SPI word transmitted
rx_start  output  1  one-cycle pulse requesting an SPI receive
tx_start  output  1  one-cycle pulse requesting an SPI transmit
tx_data  output  DATA_WIDTH  word to transmit; held stable from the tx_start pulse until tx_done
product  output  2*DATA_WIDTH  last completed product, registered
result_valid  output  1  one-cycle pulse when product updates
busy  output  1  high in every state except IDLE
timeout_err  output  1  sticky; set on operand-B timeout
overrun_err  output  1  sticky; set by rx_valid in MUL/TX_HI/TX_LO

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE. All outputs 0, including product, tx_data and both sticky flags. Iteration and timeout counters 0. Takes effect at the next edge from any state, including mid-multiply or mid-transmit. No tx_start/rx_start is issued in the cycle after reset.
- Sticky flags clear only on reset.
- All outputs are registered.
- States: IDLE, RX_A, RX_B, MUL, TX_HI, TX_LO.
- IDLE:
  - If enable=1: pulse rx_start and go to RX_A.
  - Otherwise stay in IDLE.
- RX_A:
  - Wait indefinitely for rx_valid.
  - On rx_valid: latch op_a=rx_data, pulse rx_start, clear the timeout counter, go to RX_B.
- RX_B:
  - Timeout counter increments every cycle.
  - On rx_valid: latch op_b, go to MUL.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES before rx_valid: set timeout_err and go to IDLE. op_a is discarded.
  - rx_valid in the same cycle the counter reaches TIMEOUT_CYCLES: the operand wins; no error.
- MUL:
  - Unsigned radix-2 shift-add, exactly DATA_WIDTH iterations, one per cycle.
  - Accumulator width 2*DATA_WIDTH+1 internally; no truncation.
  - After the last iteration (DATA_WIDTH cycles in MUL):
    - product is registered and result_valid pulses.
    - tx_data=product[31:16] and tx_start pulses in that same cycle.
    - State goes to TX_HI.
  - Latency: rx_valid for B at edge t → result_valid/tx_start high in the cycle after edge t+1+DATA_WIDTH.
- TX_HI:
  - On tx_done: tx_data=product[15:0], pulse tx_start, go to TX_LO.
- TX_LO:
  - On tx_done: go to IDLE.
  - The next frame starts only after one IDLE cycle.
- Ignored and error events:
  - tx_done outside TX_HI/TX_LO is ignored.
  - rx_valid in MUL/TX_HI/TX_LO is dropped and sets overrun_err.
  - rx_valid in IDLE is ignored silently.
- enable deasserted mid-frame has no effect; the frame completes.
- rx_start and tx_start are never high in the same cycle.

Optional Feature:
Macro: SIGNED_MULT_EN
- Defined:
  - Operands are two's complement.
  - The multiplier takes magnitudes of op_a and op_b, runs the same DATA_WIDTH-iteration unsigned core, then negates the product when the sign bits differ.
  - One extra cycle is added in MUL for the sign fix-up, so latency is DATA_WIDTH+1 cycles.
  - -32768 × -32768 = 0x40000000, with no overflow.
- Undefined: unsigned operation, latency as above, and no sign logic is synthesised.

Test Plan:
1. Unsigned product: enable=1, op_a=0x0003, op_b=0x0005.
   - Response: product=0x0000000F; tx words 0x0000 then 0x000F; result_valid pulses exactly 17 cycles after B's rx_valid edge (DATA_WIDTH+1); busy returns low after the second tx_done.
2. Maximum operands: op_a=op_b=0xFFFF.
   - Response: product=0xFFFE0001; tx words 0xFFFE then 0x0001.
   - With SIGNED_MULT_EN: product=0x00000001.
3. Operand-B timeout: TIMEOUT_CYCLES=20; deliver A, then no rx_valid.
   - Response: timeout_err=1 at cycle 20 after A; state IDLE; a new rx_start follows if enable=1.
   - Repeat with rx_valid on exactly cycle 20: no error, multiply proceeds.
4. Overrun: inject rx_valid during MUL and during TX_HI.
   - Response: overrun_err=1 sticky; product unaffected; tx sequence still correct.
5. Reset mid-operation: assert reset for 1 cycle at MUL iteration 8.
   - Response: next cycle all outputs 0 and state IDLE; no tx_start observed; the next frame 0x0007 × 0x0009 yields 0x0000003F.
6. Spurious tx_done in IDLE/RX_A, plus a tx_done delayed 100 cycles in TX_HI.
   - Response: spurious tx_done ignored; tx_data holds 0x0000 (high word) until tx_done arrives; then the low word is sent.

Source files
------------

// File: rtl/spi_mult_frame_ctrl.sv
// SPI frame controller: fetches two operand words, multiplies them in a shift-add core, returns the product high word first.
// Optional macro SIGNED_MULT_EN: two's-complement operands, one extra sign fix-up cycle in MUL.
module spi_mult_frame_ctrl #(
    parameter int          DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    input  logic                    tx_done,
    output logic                    rx_start,
    output logic                    tx_start,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    overrun_err,
    output logic [2:0]              dbg_state
);

    // Handshake: rx_start/tx_start are one-cycle requests to the SPI engine; rx_valid and
    // tx_done are one-cycle completions. A completion is consumed only in the state waiting
    // for it; tx_data stays stable from its tx_start until the matching tx_done.

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RX_A  = 3'd1;
    localparam logic [2:0] RX_B  = 3'd2;
    localparam logic [2:0] MUL   = 3'd3;
    localparam logic [2:0] TX_HI = 3'd4;
    localparam logic [2:0] TX_LO = 3'd5;

    localparam int CW = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0] ITERS = CW'(DATA_WIDTH);
`ifdef SIGNED_MULT_EN
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH + 1);
`else
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
`endif

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   mag_a;
    logic [DATA_WIDTH-1:0]   mag_b;
    logic [2*DATA_WIDTH:0]   acc;
    logic [2*DATA_WIDTH:0]   acc_step;
    logic [DATA_WIDTH:0]     upper_sum;
    logic [CW-1:0]           iter;
    logic [31:0]             to_cnt;
    logic                    to_hit;

`ifdef SIGNED_MULT_EN
    logic neg;
    assign mag_a = op_a[DATA_WIDTH-1] ? -op_a : op_a;
    assign mag_b = rx_data[DATA_WIDTH-1] ? -rx_data : rx_data;
`else
    assign mag_a = op_a;
    assign mag_b = rx_data;
`endif

    // Multiplier lives in acc[DATA_WIDTH-1:0] and is consumed LSB first; partial sum grows from the top.
    assign upper_sum = acc[2*DATA_WIDTH:DATA_WIDTH] + (acc[0] ? {1'b0, mag_a} : '0);
    assign acc_step  = {upper_sum, acc[DATA_WIDTH-1:0]} >> 1;

    assign to_hit    = (TIMEOUT_CYCLES != 0) && ((to_cnt + 32'd1) == TIMEOUT_CYCLES);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)   state_nxt = RX_A;
            RX_A:    if (rx_valid) state_nxt = RX_B;
            RX_B: begin
                if (rx_valid)    state_nxt = MUL;
                else if (to_hit) state_nxt = IDLE;
            end
            MUL:     if (iter == LAST) state_nxt = TX_HI;
            TX_HI:   if (tx_done)  state_nxt = TX_LO;
            TX_LO:   if (tx_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rx_start     <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            product      <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
            op_a         <= '0;
            acc          <= '0;
            iter         <= '0;
            to_cnt       <= '0;
`ifdef SIGNED_MULT_EN
            neg          <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != IDLE);
            rx_start     <= 1'b0;
            tx_start     <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) rx_start <= 1'b1;
                end
                RX_A: begin
                    if (rx_valid) begin
                        op_a     <= rx_data;
                        rx_start <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                RX_B: begin
                    if (rx_valid) begin
                        acc  <= {{(DATA_WIDTH+1){1'b0}}, mag_b};
                        iter <= '0;
`ifdef SIGNED_MULT_EN
                        neg  <= op_a[DATA_WIDTH-1] ^ rx_data[DATA_WIDTH-1];
`endif
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                        if (to_hit) timeout_err <= 1'b1;
                    end
                end
                MUL: begin
                    if (iter < ITERS) begin
                        acc  <= acc_step;
                        iter <= iter + CW'(1);
                    end
`ifdef SIGNED_MULT_EN
                    else if (iter != LAST) begin
                        if (neg) acc <= {1'b0, -acc[2*DATA_WIDTH-1:0]};
                        iter <= iter + CW'(1);
                    end
`endif
                    else begin
                        product      <= acc[2*DATA_WIDTH-1:0];
                        result_valid <= 1'b1;
                        tx_data      <= acc[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_start     <= 1'b1;
                    end
                    if (rx_valid) overrun_err <= 1'b1;
                end
                TX_HI: begin
                    if (tx_done) begin
                        tx_data  <= product[DATA_WIDTH-1:0];
                        tx_start <= 1'b1;
                    end
                    if (rx_valid) overrun_err <= 1'b1;
                end
                TX_LO: begin
                    if (rx_valid) overrun_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mult_frame_ctrl.sv
// Bench for spi_mult_frame_ctrl: random and directed frames against an arithmetic product model.
module tb_spi_mult_frame_ctrl;
    localparam int W = 16;
`ifdef SIGNED_MULT_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic          clk;
    logic          reset;
    logic          enable;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          tx_done;
    logic          rx_start;
    logic          tx_start;
    logic [W-1:0]  tx_data;
    logic [2*W-1:0] product;
    logic          result_valid;
    logic          busy;
    logic          timeout_err;
    logic          overrun_err;
    logic [2:0]    dbg_state;

    logic          tx_done_resp;
    logic          tx_done_spur;
    assign tx_done = tx_done_resp | tx_done_spur;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int a_edge = 0;
    int b_edge = 0;
    int hi_delay = 0;
    logic [W-1:0] cur_a;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   exp_tx_q[$];
    int             exp_t_q[$];

    spi_mult_frame_ctrl #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_done(tx_done), .rx_start(rx_start),
        .tx_start(tx_start), .tx_data(tx_data), .product(product),
        .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err),
        .overrun_err(overrun_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_MULT_EN
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:0];
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic wait_rx_start();
        int n = 0;
        while (!rx_start && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rx_start_seen", {31'd0, rx_start}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("busy_low", {31'd0, busy}, 32'd0);
    endtask

    task automatic give_a(input logic [W-1:0] a, input int d);
        repeat (d) @(negedge clk);
        rx_data  = a;
        rx_valid = 1'b1;
        cur_a    = a;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = W'($urandom);
        a_edge   = cyc;
    endtask

    task automatic give_b(input logic [W-1:0] b, input int d, input bit push);
        logic [2*W-1:0] p;
        repeat (d) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = W'($urandom);
        b_edge   = cyc;
        if (push) begin
            p = model(cur_a, b);
            exp_q.push_back(p);
            exp_t_q.push_back(b_edge);
            exp_tx_q.push_back(p[2*W-1:W]);
            exp_tx_q.push_back(p[W-1:0]);
        end
    endtask

    task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b, input int da, input int db);
        enable = 1'b1;
        wait_rx_start();
        enable = 1'b0;
        give_a(a, da);
        wait_rx_start();
        give_b(b, db, 1'b1);
    endtask

    // SPI transmit side: answers each tx_start, checks the word and that it stays stable
    initial begin : tx_responder
        int idx;
        int d;
        logic [W-1:0] word;
        logic held;
        idx = 0;
        tx_done_resp = 1'b0;
        forever begin
            @(negedge clk);
            while (tx_start) begin
                word = tx_data;
                if (exp_tx_q.size() == 0) check("unexpected_tx_start", 32'd1, 32'd0);
                else if (idx == 0) check("tx_hi_word", {16'd0, word}, {16'd0, exp_tx_q.pop_front()});
                else check("tx_lo_word", {16'd0, word}, {16'd0, exp_tx_q.pop_front()});
                d = (idx == 0 && hi_delay > 0) ? hi_delay : int'($urandom_range(0, 4));
                held = 1'b1;
                repeat (d) begin
                    @(negedge clk);
                    if (tx_data !== word || tx_start) held = 1'b0;
                end
                check("tx_data_held", {31'd0, held}, 32'd1);
                tx_done_resp = 1'b1;
                @(negedge clk);
                tx_done_resp = 1'b0;
                idx = 1 - idx;
            end
        end
    end

    // scoreboard monitor for completed products
    initial begin : result_monitor
        logic [2*W-1:0] e;
        int t;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("product", product, e);
                    check("latency", cyc - t, LAT);
                    check("tx_start_with_result", {31'd0, tx_start}, 32'd1);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0; enable = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_done_spur = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_product", product, 32'd0);
        check("rst_tx_data", {16'd0, tx_data}, 32'd0);
        check("rst_flags", {27'd0, busy, timeout_err, overrun_err, rx_start, tx_start}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // basic product; busy must drop once both words are out
        frame(16'h0003, 16'h0005, 0, 0);
        wait_idle();
        check("idle_after_frame", {29'd0, dbg_state}, 32'd0);

        // maximum and corner operands
        frame(16'hFFFF, 16'hFFFF, 1, 2);
        frame(16'h8000, 16'h8000, 0, 3);
        frame(16'h0000, 16'hBEEF, 2, 0);
        frame(16'h7FFF, 16'h8001, 0, 1);

        for (int i = 0; i < 20; i++)
            frame(W'($urandom), W'($urandom), $urandom_range(0, 5), $urandom_range(0, 10));
        wait_idle();

        // operand B arriving on the timeout cycle wins
        enable = 1'b1;
        wait_rx_start();
        enable = 1'b0;
        give_a(16'h0011, 0);
        wait_rx_start();
        give_b(16'h0022, 19, 1'b1);
        wait_idle();
        check("no_timeout_at_limit", {31'd0, timeout_err}, 32'd0);

        // operand B never arrives
        enable = 1'b1;
        wait_rx_start();
        give_a(16'h0055, 0);
        repeat (19) @(negedge clk);
        check("timeout_not_yet", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("timeout_set", {31'd0, timeout_err}, 32'd1);
        check("timeout_state_idle", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        check("rx_start_after_timeout", {31'd0, rx_start}, 32'd1);
        enable = 1'b0;
        give_a(16'h0002, 0);
        wait_rx_start();
        give_b(16'h0003, 3, 1'b1);
        wait_idle();
        check("timeout_sticky", {31'd0, timeout_err}, 32'd1);

        // overrun during MUL and TX_HI
        check("overrun_clear", {31'd0, overrun_err}, 32'd0);
        enable = 1'b1;
        wait_rx_start();
        enable = 1'b0;
        give_a(16'h1234, 0);
        wait_rx_start();
        give_b(16'h0FED, 2, 1'b1);
        repeat (4) @(negedge clk);
        rx_data = 16'hDEAD; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("overrun_in_mul", {31'd0, overrun_err}, 32'd1);
        begin
            int n = 0;
            while (dbg_state != 3'd4 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("reached_tx_hi", {29'd0, dbg_state}, 32'd4);
        rx_data = 16'hBEEF; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("overrun_sticky", {31'd0, overrun_err}, 32'd1);
        wait_idle();

        // reset pulse at MUL iteration 8 abandons the frame
        enable = 1'b1;
        wait_rx_start();
        enable = 1'b0;
        give_a(16'h1234, 1);
        wait_rx_start();
        give_b(16'h5678, 0, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_product", product, 32'd0);
        check("midrst_tx_data", {16'd0, tx_data}, 32'd0);
        check("midrst_strobes", {29'd0, rx_start, tx_start, result_valid}, 32'd0);
        check("midrst_flags", {29'd0, busy, timeout_err, overrun_err}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        frame(16'h0007, 16'h0009, 0, 0);
        wait_idle();

        // spurious tx_done in IDLE and RX_A, then a slow tx_done on the high word
        tx_done_spur = 1'b1;
        @(negedge clk);
        tx_done_spur = 1'b0;
        check("spur_idle_state", {29'd0, dbg_state}, 32'd0);
        check("spur_idle_tx_start", {31'd0, tx_start}, 32'd0);
        enable = 1'b1;
        wait_rx_start();
        enable = 1'b0;
        tx_done_spur = 1'b1;
        @(negedge clk);
        tx_done_spur = 1'b0;
        check("spur_rxa_state", {29'd0, dbg_state}, 32'd1);
        check("spur_rxa_tx_start", {31'd0, tx_start}, 32'd0);
        give_a(16'h00AB, 0);
        wait_rx_start();
        hi_delay = 100;
        give_b(16'h0101, 0, 1'b1);
        wait_idle();
        hi_delay = 0;

        repeat (20) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("exp_tx_q_drained", exp_tx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
